// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider: per-channel tick strobe and 50%-duty divided clock.
// Optional macro CLKDIV_SYNC_EN adds a sync input that realigns every channel.
module prog_clock_divider #(
   parameter int                N_CH        = 4,
   parameter int                W           = 32,
   parameter longint unsigned   DEFAULT_DIV = 50000000,
   localparam int               CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_CH-1:0]   ch_en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [W-1:0]      cfg_div,
`ifdef CLKDIV_SYNC_EN
   input  logic              sync,
`endif
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   clk_out
);

   localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
   localparam logic [W-1:0] ONE     = W'(1);

   logic [W-1:0]    r_cnt      [N_CH];
   logic [W-1:0]    r_div_act  [N_CH];
   logic [W-1:0]    r_div_pend [N_CH];
   logic [N_CH-1:0] r_pend;
   logic [N_CH-1:0] r_tick;
   logic [N_CH-1:0] r_clk_out;

   logic            w_cfg_ready;
   logic [N_CH-1:0] w_accept;
   logic [N_CH-1:0] w_run;
   logic [W-1:0]    w_cfg_div;

   // A zero divisor would never reach a terminal count, so it is clamped to 1.
   function automatic logic [W-1:0] sat_div(input logic [W-1:0] d);
      return (d == '0) ? ONE : d;
   endfunction

   // Channel indices beyond N_CH match no channel and leave ready high, so such writes are dropped.
   always_comb begin
      w_cfg_ready = 1'b1;
      w_accept    = '0;
      w_run       = '0;
      w_cfg_div   = sat_div(cfg_div);
      for (int i = 0; i < N_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            w_cfg_ready = !r_pend[i];
         end
         w_run[i] = enable && ch_en[i];
      end
      for (int i = 0; i < N_CH; i++) begin
         w_accept[i] = cfg_valid && w_cfg_ready && (cfg_ch == CH_W'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend    <= '0;
         r_tick    <= '0;
         r_clk_out <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_cnt[i]     <= '0;
            r_div_act[i] <= DEF_DIV;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
`ifdef CLKDIV_SYNC_EN
            if (sync) begin
               r_cnt[i]     <= '0;
               r_clk_out[i] <= 1'b0;
               r_tick[i]    <= 1'b0;
               if (r_pend[i]) begin
                  r_div_act[i] <= r_div_pend[i];
                  r_pend[i]    <= 1'b0;
               end
            end else
`endif
            if (w_run[i]) begin
               if (r_cnt[i] == r_div_act[i] - ONE) begin
                  r_cnt[i]     <= '0;
                  r_tick[i]    <= 1'b1;
                  r_clk_out[i] <= !r_clk_out[i];
                  if (r_pend[i]) begin
                     r_div_act[i] <= r_div_pend[i];
                     r_pend[i]    <= 1'b0;
                  end
               end else begin
                  r_cnt[i]  <= r_cnt[i] + ONE;
                  r_tick[i] <= 1'b0;
               end
            end else begin
               r_tick[i] <= 1'b0;
               // A stopped channel has no terminal to wait for, so the new divisor restarts the count now.
               if (r_pend[i]) begin
                  r_div_act[i] <= r_div_pend[i];
                  r_cnt[i]     <= '0;
                  r_pend[i]    <= 1'b0;
               end
            end
            // Acceptance needs pend clear, so it never collides with the apply paths above.
            if (w_accept[i]) begin
               r_pend[i] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (w_accept[i]) begin
            r_div_pend[i] <= w_cfg_div;
         end
      end
   end

   assign cfg_ready = w_cfg_ready;
   assign tick      = r_tick;
   assign clk_out   = r_clk_out;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (N_CH=4, DEFAULT_DIV=5).
module tb_prog_clock_divider;

   localparam int N_CH = 4;
   localparam int W    = 32;

   logic            clk;
   logic            reset;
   logic            enable;
   logic [N_CH-1:0] ch_en;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [1:0]      cfg_ch;
   logic [W-1:0]    cfg_div;
   logic [N_CH-1:0] tick;
   logic [N_CH-1:0] clk_out;
`ifdef CLKDIV_SYNC_EN
   logic            sync;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [N_CH-1:0] exp_clk;
   logic [N_CH-1:0] exp_tick;

   prog_clock_divider #(
      .N_CH        (N_CH),
      .W           (W),
      .DEFAULT_DIV (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
`ifdef CLKDIV_SYNC_EN
      .sync      (sync),
`endif
      .tick      (tick),
      .clk_out   (clk_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected tick pattern of the main scenario, cycle 1 = first edge after reset.
   // ch0: D=5 with a 7-cycle stall (23..29) and a stopped rewrite to D=2 applied at edge 43.
   // ch1: D=5, rewritten to D=3 and applied at the terminal of cycle 10.
   // ch2: rewritten to 0 (stored as 1), applied at cycle 5, then ticks every cycle.
   // ch3: untouched D=5.
   function automatic logic [N_CH-1:0] main_tick(input int c);
      logic [N_CH-1:0] t;
      t    = '0;
      t[0] = (c inside {5, 10, 15, 20, 32, 37, 45, 47, 49});
      t[1] = (c == 5) || (c >= 10 && ((c - 10) % 3) == 0);
      t[2] = (c >= 5);
      t[3] = ((c % 5) == 0);
      return t;
   endfunction

   initial begin
      reset     = 1'b1;
      enable    = 1'b1;
      ch_en     = '1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
      sync      = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_tick", 32'(tick), 32'h0);
      check("reset_clk_out", 32'(clk_out), 32'h0);
      check("reset_ready", 32'(cfg_ready), 32'h1);
      reset   = 1'b0;
      exp_clk = '0;

      for (int c = 1; c <= 50; c++) begin
         @(posedge clk);
         #1;
         exp_tick = main_tick(c);
         exp_clk  = exp_clk ^ exp_tick;
         check($sformatf("main_tick_c%0d", c), 32'(tick), 32'(exp_tick));
         check($sformatf("main_clk_c%0d", c), 32'(clk_out), 32'(exp_clk));
         case (c)
            1: begin
               cfg_ch = 2'd2; cfg_div = 0; cfg_valid = 1'b1;
               #1 check("ready_ch2_idle", 32'(cfg_ready), 32'h1);
            end
            2, 3, 4: begin
               cfg_valid = 1'b0;
               #1 check($sformatf("ready_ch2_pend_c%0d", c), 32'(cfg_ready), 32'h0);
            end
            5: check("ready_ch2_applied", 32'(cfg_ready), 32'h1);
            7: begin
               cfg_ch = 2'd1; cfg_div = 3; cfg_valid = 1'b1;
               #1 check("ready_ch1_idle", 32'(cfg_ready), 32'h1);
            end
            8, 9: begin
               cfg_valid = 1'b0;
               #1 check($sformatf("ready_ch1_pend_c%0d", c), 32'(cfg_ready), 32'h0);
            end
            10: check("ready_ch1_applied", 32'(cfg_ready), 32'h1);
            22: ch_en[0] = 1'b0;
            29: ch_en[0] = 1'b1;
            40: ch_en[0] = 1'b0;
            41: begin
               cfg_ch = 2'd0; cfg_div = 2; cfg_valid = 1'b1;
               #1 check("ready_ch0_idle", 32'(cfg_ready), 32'h1);
            end
            42: begin
               cfg_valid = 1'b0;
               #1 check("ready_ch0_pend", 32'(cfg_ready), 32'h0);
            end
            43: begin
               check("ready_ch0_stopped_apply", 32'(cfg_ready), 32'h1);
               ch_en[0] = 1'b1;
            end
            50: begin
               cfg_ch = 2'd3; cfg_div = 7; cfg_valid = 1'b1;
            end
            default: ;
         endcase
      end

      // Write to ch3 accepted at edge 51, then reset while it is still pending.
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      #1 check("ready_ch3_pend", 32'(cfg_ready), 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_tick", 32'(tick), 32'h0);
      check("midreset_clk_out", 32'(clk_out), 32'h0);
      check("midreset_ready_ch3", 32'(cfg_ready), 32'h1);
      reset   = 1'b0;
      exp_clk = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         exp_tick = ((c % 5) == 0) ? 4'hF : 4'h0;
         exp_clk  = exp_clk ^ exp_tick;
         check($sformatf("postreset_tick_c%0d", c), 32'(tick), 32'(exp_tick));
         check($sformatf("postreset_clk_c%0d", c), 32'(clk_out), 32'(exp_clk));
      end

`ifdef CLKDIV_SYNC_EN
      // Stopped writes: ch0 -> D=4, ch1 -> D=6, each active the edge after acceptance.
      enable = 1'b0;
      cfg_ch = 2'd0; cfg_div = 4; cfg_valid = 1'b1;
      @(posedge clk);
      #1;
      cfg_ch = 2'd1; cfg_div = 6;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      enable = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      sync = 1'b1;
      @(posedge clk);
      #1;
      sync = 1'b0;
      check("sync_clk_out", 32'(clk_out), 32'h0);
      check("sync_tick", 32'(tick), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         exp_tick    = '0;
         exp_tick[0] = (k == 4);
         exp_tick[1] = (k == 6);
         exp_tick[2] = (k == 5);
         exp_tick[3] = (k == 5);
         check($sformatf("postsync_tick_k%0d", k), 32'(tick), 32'(exp_tick));
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/prog_clock_divider.md
# prog_clock_divider

Multi-channel, runtime-programmable clock divider for generating slow enables and divided clocks from the single board clock. Each of `N_CH` channels owns an independent divisor loaded through a valid/ready configuration port. Each channel produces a one-cycle `tick` strobe every D enabled cycles and a 50%-duty `clk_out` with a period of 2·D cycles. Divisor changes take effect only at a terminal count, so neither output ever produces a runt period. The block replaces fixed-parameter dividers in display-refresh, debounce and timer paths.

## Interface

Parameters:
- `N_CH`, default 4: number of independent channels (1..16).
- `W`, default 32: counter and divisor width.
- `DEFAULT_DIV`, default 50000000: divisor loaded into every channel at reset. Must be ≥1 and < 2^W.

Ports:
- `clk`, input, 1: sole clock; all logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: global count enable.
- `ch_en`, input, N_CH: per-channel count enable.
- `cfg_valid`, input, 1: configuration write request.
- `cfg_ready`, output, 1: combinational; equals `!pend[cfg_ch]`. It is 1 when `cfg_ch` ≥ N_CH.
- `cfg_ch`, input, max(1,$clog2(N_CH)): target channel.
- `cfg_div`, input, W: new divisor. A value of 0 is stored as 1.
- `tick`, output, N_CH: registered one-cycle strobe, one bit per channel.
- `clk_out`, output, N_CH: registered divided clock, one bit per channel.
- `sync`, input, 1: realign all channels. Present only with `CLKDIV_SYNC_EN`.

## Operation

- Per-channel state:
  - `cnt[W]`: current count.
  - `div_act[W]`: active divisor.
  - `div_pend[W]`: pending divisor.
  - `pend`: pending-write flag.
- Reset values, for all channels:
  - `cnt`=0, `div_act`=DEFAULT_DIV, `pend`=0.
  - `tick`=0, `clk_out`=0.
  - Reset mid-operation discards pending writes.
- A channel is running when `enable && ch_en[i]`.
- Running, `cnt != div_act-1`: `cnt` increments by 1 and `tick[i]` is 0.
- Running, `cnt == div_act-1` (terminal):
  - `cnt` goes to 0.
  - `tick[i]` is 1 for the next cycle.
  - `clk_out[i]` toggles.
  - If `pend` is set, `div_act` takes `div_pend` and `pend` clears.
- Not running:
  - `cnt` and `clk_out` hold; `tick` is 0.
  - If `pend` is set, `div_act` takes `div_pend`, `cnt` clears to 0 and `pend` clears, all on that edge.
- Config handshake:
  - A write is accepted on an edge where `cfg_valid && cfg_ready`.
  - On acceptance, `div_pend[cfg_ch]` takes `cfg_div` (0 becomes 1) and `pend` is set.
  - A write to `cfg_ch` ≥ N_CH is accepted and dropped.
  - Only one write per channel can be outstanding. `cfg_ready` stays low until that channel's pending write is applied.
- Accept on the same edge as that channel's terminal count: the terminal uses the old `div_act`. The new value is pending and is applied at the next terminal.
- D=1: `tick` is constantly 1 while running, and `clk_out` toggles every cycle (clk/2).
- Counter arithmetic is W-bit unsigned. With `div_act` ≤ 2^W−1, `cnt` never wraps.

## Timing

- `tick` and `clk_out` update on the same edge. The rising edge of `clk_out` coincides with every second tick, starting with the first.
- From reset deassertion with the channel running continuously and divisor D:
  - `tick` is high during cycle D, where cycle 1 is the first edge after reset.
  - `tick` is then high every D cycles after that.
- Config latency:
  - Running channel: the new divisor governs the count that starts after the next terminal.
  - Stopped channel: the new divisor is active on the edge after acceptance.
- `cfg_ready` has no register stage, so it is valid in the same cycle as `cfg_ch`.

## Configuration

- `CLKDIV_SYNC_EN` defined:
  - The `sync` port exists.
  - On an edge with `sync`=1 (and `reset`=0), every channel gets `cnt`=0, `clk_out`=0 and `tick`=0, and any pending divisor is applied immediately, regardless of the enables.
  - `sync` has priority over counting and below `reset`.
  - A config write accepted on the same edge becomes pending and is not applied by that `sync`.
- `CLKDIV_SYNC_EN` undefined:
  - No `sync` port and no sync logic.
  - Channels are aligned only by `reset`.

## Test plan

- Reset, then N_CH=4, DEFAULT_DIV=5, all enables high for 40 cycles → each `tick` is high in cycles 5, 10, 15…. `clk_out` rises at cycle 5, falls at cycle 10, period 10.
- Channel 1 running with D=5; write `cfg_div`=3 at cycle 7 → the tick at cycle 10 keeps the 5-cycle spacing, the next ticks are at 13 and 16, and `cfg_ready` for ch1 is low from cycle 8 until the edge at 10.
- Write `cfg_div`=0 to channel 2 → behaves as D=1: `tick[2]` stays 1 and `clk_out[2]` toggles every cycle.
- Drop `ch_en[0]` for 7 cycles mid-count → `cnt`, `clk_out` and tick spacing resume with no lost or extra ticks. A write issued while the channel is stopped is active on the next edge and restarts the count from 0.
- Assert `reset` mid-count with a write pending → all outputs are 0 on the next edge, `pend` clears, and `div_act` returns to DEFAULT_DIV.
- With `CLKDIV_SYNC_EN`: channels at D=4 and D=6 with arbitrary phase; pulse `sync` → both `clk_out` bits are 0, and the next ticks occur 4 and 6 cycles after the sync edge.
